register_file_scoreboard: RTL
=============================

// Module: register_file_scoreboard
// PURPOSE
//  Integer register file at the consumer end of the write-back path.
//  - Write-back selection delivers iWrData/iWrAddr/iWrEn each cycle.
//  - Decode reads two source operands combinationally.
//  - A per-register pending (scoreboard) bit is set when an instruction issues with a destination.
//    It is cleared when that destination is written back, so decode can stall on RAW hazards.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register index width; 2**ADDR_W registers, R0 hardwired to zero
// PORTS
//  iClk        in   1       clock; all state updates on rising edge
//  iRst_n      in   1       reset, asynchronous, active-low
//  iWrEn       in   1       write-back strobe
//  iWrAddr     in   ADDR_W  write-back destination register
//  iWrData     in   DATA_W  write-back data
//  iIssueEn    in   1       instruction issued with a destination register
//  iIssueAddr  in   ADDR_W  destination of the issuing instruction
//  iRdAddrA    in   ADDR_W  source operand A index
//  iRdAddrB    in   ADDR_W  source operand B index
//  oRdDataA    out  DATA_W  operand A value
//  oRdDataB    out  DATA_W  operand B value
//  oBusyA      out  1       operand A register has a write-back pending
//  oBusyB      out  1       operand B register has a write-back pending
// BEHAVIOUR
//  - Reset (iRst_n=0, async):
//    - All registers and all pending bits clear to 0 immediately.
//    - While reset is held: oRdDataA/B=0 and oBusyA/B=0.
//  - Write: on a rising edge with iWrEn=1 and iWrAddr!=0, reg[iWrAddr] <= iWrData.
//    The new value is readable from the next cycle.
//  - Reads are combinational, zero latency. Index 0 always returns 0 and busy 0.
//  - Scoreboard, per rising edge, for register r (r!=0):
//    - Set when iIssueEn=1 and iIssueAddr==r.
//    - Clear when iWrEn=1 and iWrAddr==r.
//    - Set and clear on the same r in the same cycle: set wins, pending stays 1.
//      The newer instruction owns the register; the data write still occurs.
//    - Write to a non-pending register: allowed; data updates, pending bit stays 0.
//    - Issue to an already-pending register: pending stays 1. No count is kept;
//      the first matching write-back clears it.
//  - R0: writes ignored; issue to R0 never sets pending.
//  - Both read ports may address the same register; each returns identical data and busy.
//  - Reset asserted mid-operation discards any same-cycle write or issue.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined (same-cycle write-to-read forwarding):
//    - If iWrEn=1, iWrAddr!=0 and iRdAddrX==iWrAddr, oRdDataX=iWrData.
//    - Under the same condition, oBusyX=0 unless iIssueEn targets that register in the same cycle.
//  REGFILE_BYPASS_EN undefined:
//    - Reads return the stored value and the registered pending bit.
//    - A same-cycle write becomes visible next cycle.
// TESTING
//  1 Write R5=0xDEADBEEF, then iRst_n=0 mid-cycle -> oRdDataA(R5)=0 and oBusyA=0 at once, without waiting for a clock edge.
//  2 Write R5=0xDEADBEEF; next cycle iRdAddrA=5, iRdAddrB=5 -> both ports 0xDEADBEEF, busy 0.
//  3 Write R0=0x1234 and issue R0; next cycle read R0 -> data 0, busy 0.
//  4 Issue R7 (cyc1); cyc2 read B=7 -> oBusyB=1; write R7=0x55 (cyc3); cyc4 -> oRdDataB=0x55, oBusyB=0.
//  5 R7 pending; same cycle issue R7 + write R7=0x66 -> next cycle data 0x66, oBusyA=1.
//  6 R3=0x0; write R3=0xA5A5A5A5 and read A=3 same cycle:
//    - With REGFILE_BYPASS_EN: 0xA5A5A5A5, busy 0.
//    - Without it: 0x0 that cycle, 0xA5A5A5A5 next cycle.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: register file with per-register pending bits for RAW stall detection.
// Optional REGFILE_BYPASS_EN forwards a same-cycle write-back to the read ports.
module register_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iWrEn,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iIssueEn,
    input  logic [ADDR_W-1:0] iIssueAddr,
    input  logic [ADDR_W-1:0] iRdAddrA,
    input  logic [ADDR_W-1:0] iRdAddrB,
    output logic [DATA_W-1:0] oRdDataA,
    output logic [DATA_W-1:0] oRdDataB,
    output logic              oBusyA,
    output logic              oBusyB
);
    localparam int N = 2 ** ADDR_W;
    logic [DATA_W-1:0] r_regs [N];
    logic [N-1:0]      r_pend;
    logic              w_wr_ok;
    logic              w_iss_ok;
    assign w_wr_ok  = iWrEn && (iWrAddr != '0);
    assign w_iss_ok = iIssueEn && (iIssueAddr != '0);
    // Issue is applied after clear so a same-cycle issue keeps the register owned.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < N; i++) r_regs[i] <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr_ok) r_regs[iWrAddr] <= iWrData;
            if (w_wr_ok) r_pend[iWrAddr] <= 1'b0;
            if (w_iss_ok) r_pend[iIssueAddr] <= 1'b1;
        end
    end
`ifdef REGFILE_BYPASS_EN
    logic w_hit_a;
    logic w_hit_b;
    assign w_hit_a = iRst_n && w_wr_ok && (iRdAddrA == iWrAddr);
    assign w_hit_b = iRst_n && w_wr_ok && (iRdAddrB == iWrAddr);
    always_comb begin
        oRdDataA = w_hit_a ? iWrData : r_regs[iRdAddrA];
        oRdDataB = w_hit_b ? iWrData : r_regs[iRdAddrB];
        oBusyA   = w_hit_a ? (w_iss_ok && iIssueAddr == iRdAddrA) : r_pend[iRdAddrA];
        oBusyB   = w_hit_b ? (w_iss_ok && iIssueAddr == iRdAddrB) : r_pend[iRdAddrB];
    end
`else
    always_comb begin
        oRdDataA = r_regs[iRdAddrA];
        oRdDataB = r_regs[iRdAddrB];
        oBusyA   = r_pend[iRdAddrA];
        oBusyB   = r_pend[iRdAddrB];
    end
`endif
endmodule
